// File: rtl/flag_sync_pkg.sv
// Shared types and constants for the multi-channel flag synchroniser.
package flag_sync_pkg;

  typedef enum logic [1:0] {
    LEVEL = 2'd0,
    RISE  = 2'd1,
    FALL  = 2'd2,
    BOTH  = 2'd3
  } edge_mode_e;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_N_CH        = 32;

  // Width of a channel selector; a single channel still needs one select bit.
  function automatic int sel_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/flag_sync_chan.sv
// One flag channel: synchroniser chain, edge detector, pulse, sticky
// pending/overflow flags and a saturating event counter.
module flag_sync_chan
  import flag_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             async_i,
  input  logic             clr_i,
  output logic             level_o,
  output logic             pulse_o,
  output logic             pending_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam edge_mode_e       MODE    = edge_mode_e'(EDGE_MODE[1:0]);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   pulse_q, pulse_d;
  logic                   pending_q, pending_d;
  logic                   overflow_q, overflow_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_s;
  logic                   event_s;

  assign level_s = sync_q[SYNC_STAGES-1];

  // Event detection and next-state for all channel state.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], async_i};
    prev_d     = level_s;
    event_s    = 1'b0;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    cnt_d      = cnt_q;

    case (MODE)
      LEVEL:   event_s = level_s;
      RISE:    event_s = level_s & ~prev_q;
      FALL:    event_s = ~level_s & prev_q;
      BOTH:    event_s = level_s ^ prev_q;
      default: event_s = 1'b0;
    endcase

    pulse_d = event_s;

    // A clear only wipes history older than a coincident event, so the event still counts.
    if (clr_i) begin
      pending_d  = event_s;
      overflow_d = 1'b0;
      cnt_d      = event_s ? CNT_ONE : '0;
    end else if (event_s) begin
      pending_d  = 1'b1;
      overflow_d = overflow_q | pending_q;
      cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    end else begin
      pending_d  = pending_q;
      overflow_d = overflow_q;
      cnt_d      = cnt_q;
    end
  end

  // Channel state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      pulse_q    <= 1'b0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      pulse_q    <= pulse_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
    end
  end

  assign level_o    = level_s;
  assign pulse_o    = pulse_q;
  assign pending_o  = pending_q;
  assign overflow_o = overflow_q;
  assign cnt_o      = cnt_q;

endmodule

// File: rtl/flag_sync_multi.sv
// N-channel receiver for asynchronous flags; one flag_sync_chan per input
// plus a read mux over the per-channel event counters.
module flag_sync_multi
  import flag_sync_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1,
  parameter int CNT_W       = 8,
  localparam int SEL_W      = sel_width(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  async_in,
  input  logic [N_CH-1:0]  clr,
  input  logic [SEL_W-1:0] cnt_sel,
  output logic [N_CH-1:0]  level_out,
  output logic [N_CH-1:0]  pulse_out,
  output logic [N_CH-1:0]  pending,
  output logic [N_CH-1:0]  overflow,
  output logic [CNT_W-1:0] cnt_out
);

  logic [CNT_W-1:0] cnt_s [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    flag_sync_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_MODE   (EDGE_MODE),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .async_i    (async_in[g]),
      .clr_i      (clr[g]),
      .level_o    (level_out[g]),
      .pulse_o    (pulse_out[g]),
      .pending_o  (pending[g]),
      .overflow_o (overflow[g]),
      .cnt_o      (cnt_s[g])
    );
  end

  // Counter read mux; a select beyond the last channel matches nothing and reads 0.
  always_comb begin
    cnt_out = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_out = cnt_out | ((cnt_sel == SEL_W'(i)) ? cnt_s[i] : '0);
    end
  end

endmodule
